// File: rtl/i2c_sensor_target.sv
// I2C target exposing a latched sensor sample and a write/read config register.
// Define I2C_TARGET_AUTOINC_EN to advance the register pointer after every data byte.
module i2c_sensor_target #(
  parameter int DATA_DEPTH            = 8,
  parameter int DEVICE_ADDR           = 78,
  parameter int CONFIG_REGISTER_WRITE = 9,
  parameter int CONFIG_REGISTER_READ  = 3,
  parameter int SENSOR_DATA           = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_sda_oe,
  input  logic [DATA_DEPTH-1:0] i_sample_bits,
  input  logic                  i_sample_valid,
  output logic [DATA_DEPTH-1:0] o_conf_bits,
  output logic                  o_conf_valid
);

  localparam logic [6:0] DEV_ADDR7  = 7'(DEVICE_ADDR);
  localparam logic [7:0] IDX_CFG_WR = 8'(CONFIG_REGISTER_WRITE);
  localparam logic [7:0] IDX_CFG_RD = 8'(CONFIG_REGISTER_READ);
  localparam logic [7:0] IDX_SENSOR = 8'(SENSOR_DATA);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t                state_q, state_d;
  logic                  scl_meta_q, scl_q, scl_prev_q;
  logic                  sda_meta_q, sda_q, sda_prev_q;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  byte_done_q, byte_done_d;
  logic                  mack_q, mack_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  conf_valid_q, conf_valid_d;
  logic [7:0]            ptr_q, ptr_d;
  logic [DATA_DEPTH-1:0] shift_q, shift_d;
  logic [DATA_DEPTH-1:0] conf_q, conf_d;
  logic [DATA_DEPTH-1:0] sample_q, sample_d;
  logic                  scl_rise, scl_fall, start_det, stop_det;

  function automatic logic [DATA_DEPTH-1:0] rd_byte(input logic [7:0] p,
                                                    input logic [DATA_DEPTH-1:0] smp,
                                                    input logic [DATA_DEPTH-1:0] cfg);
    if (p == IDX_SENSOR) return smp;
    if (p == IDX_CFG_RD) return cfg;
    return '0;
  endfunction

  function automatic logic [7:0] ptr_next(input logic [7:0] p);
`ifdef I2C_TARGET_AUTOINC_EN
    return p + 8'd1;
`else
    return p;
`endif
  endfunction

  assign scl_rise  = scl_q & ~scl_prev_q;
  assign scl_fall  = ~scl_q & scl_prev_q;
  assign start_det = scl_q & scl_prev_q & sda_prev_q & ~sda_q;
  assign stop_det  = scl_q & scl_prev_q & ~sda_prev_q & sda_q;

  assign o_sda_oe     = sda_oe_q;
  assign o_conf_bits  = conf_q;
  assign o_conf_valid = conf_valid_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_done_d  = byte_done_q;
    mack_d       = mack_q;
    sda_oe_d     = sda_oe_q;
    conf_valid_d = 1'b0;
    ptr_d        = ptr_q;
    shift_d      = shift_q;
    conf_d       = conf_q;
    sample_d     = i_sample_valid ? i_sample_bits : sample_q;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d     = ADDR;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG, WDATA: begin
          if (scl_rise && !byte_done_q) begin
            shift_d   = {shift_q[DATA_DEPTH-2:0], sda_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            // Byte complete: the ACK slot opens on this falling edge.
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b1;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == DEV_ADDR7) begin
                state_d = ADDR_ACK;
              end else begin
                state_d  = IGNORE;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == REG) begin
              state_d = REG_ACK;
              ptr_d   = 8'(shift_q);
            end else begin
              state_d = WDATA_ACK;
              if (ptr_q == IDX_CFG_WR) begin
                conf_d       = shift_q;
                conf_valid_d = 1'b1;
              end
            end
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            if (state_q == ADDR_ACK && shift_q[0]) begin
              state_d  = RDATA;
              shift_d  = rd_byte(ptr_q, sample_q, conf_q);
              sda_oe_d = ~shift_d[DATA_DEPTH-1];
            end else if (state_q == ADDR_ACK) begin
              state_d = REG;
            end else begin
              state_d = WDATA;
              if (state_q == WDATA_ACK) ptr_d = ptr_next(ptr_q);
            end
          end
        end
        RDATA: begin
          if (scl_rise && !byte_done_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall) begin
            if (byte_done_q) begin
              state_d     = RDATA_ACK;
              sda_oe_d    = 1'b0;
              byte_done_d = 1'b0;
            end else begin
              shift_d  = shift_q << 1;
              sda_oe_d = ~shift_d[DATA_DEPTH-1];
            end
          end
        end
        RDATA_ACK: begin
          // Master's ACK is sampled on the rise; the next byte starts on the fall.
          if (scl_rise) begin
            mack_d = ~sda_q;
          end else if (scl_fall) begin
            ptr_d = ptr_next(ptr_q);
            if (mack_q) begin
              state_d   = RDATA;
              bit_cnt_d = 3'd0;
              shift_d   = rd_byte(ptr_d, sample_q, conf_q);
              sda_oe_d  = ~shift_d[DATA_DEPTH-1];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_meta_q   <= 1'b1;
      scl_q        <= 1'b1;
      scl_prev_q   <= 1'b1;
      sda_meta_q   <= 1'b1;
      sda_q        <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      byte_done_q  <= 1'b0;
      mack_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
      conf_valid_q <= 1'b0;
      ptr_q        <= 8'd0;
      conf_q       <= '0;
      sample_q     <= '0;
    end else begin
      scl_meta_q   <= i_scl;
      scl_q        <= scl_meta_q;
      scl_prev_q   <= scl_q;
      sda_meta_q   <= i_sda;
      sda_q        <= sda_meta_q;
      sda_prev_q   <= sda_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_done_q  <= byte_done_d;
      mack_q       <= mack_d;
      sda_oe_q     <= sda_oe_d;
      conf_valid_q <= conf_valid_d;
      ptr_q        <= ptr_d;
      conf_q       <= conf_d;
      sample_q     <= sample_d;
    end
  end

  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Scoreboard bench for i2c_sensor_target: bus master tasks queue expectations, monitors check them.
module tb_i2c_sensor_target;

  localparam int Q = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] smp_bits = 8'h00;
  logic       smp_vld = 1'b0;
  logic [7:0] conf_bits;
  logic       conf_vld;

  int   n_checks = 0;
  int   n_fail = 0;
  int   quiet_viol = 0;
  logic quiet = 1'b0;
  logic slot_chk = 1'b0;

  string      nm_q[$];
  logic       v_q[$];
  logic [7:0] conf_exp[$];

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_sensor_target dut (
    .i_clk(clk), .i_rst(rst), .i_scl(scl_m), .i_sda(sda_bus), .o_sda_oe(sda_oe),
    .i_sample_bits(smp_bits), .i_sample_valid(smp_vld),
    .o_conf_bits(conf_bits), .o_conf_valid(conf_vld)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Bus slot monitor: the resolved SDA at each checked SCL rise.
  always @(posedge scl_m) begin
    if (slot_chk) begin
      if (v_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL slot_underflow: got bus %0b, required a queued expectation", sda_bus);
      end else begin
        chk(nm_q.pop_front(), 32'(sda_bus), 32'(v_q.pop_front()));
      end
    end
  end

  // Config update monitor plus quiet-window watch on SDA drive.
  always @(negedge clk) begin
    if (conf_vld) begin
      if (conf_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL conf_valid_unexpected: got pulse with %0h, required none", conf_bits);
      end else begin
        chk("conf_bits", 32'(conf_bits), 32'(conf_exp.pop_front()));
      end
    end
    if (quiet && sda_oe) quiet_viol++;
  end

  task automatic clk_pulse();
    #Q scl_m = 1'b1;
    #(2*Q) scl_m = 1'b0;
    #Q;
  endtask

  task automatic push_slot(input string nm, input logic v);
    nm_q.push_back(nm);
    v_q.push_back(v);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic wbyte(input logic [7:0] b, input logic ack_exp);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      clk_pulse();
    end
    sda_m = 1'b1;
    push_slot("target_ack", ~ack_exp);
    slot_chk = 1'b1;
    clk_pulse();
    slot_chk = 1'b0;
  endtask

  task automatic rbyte(input logic [7:0] exp, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1;
      push_slot("read_bit", exp[i]);
      slot_chk = 1'b1;
      clk_pulse();
      slot_chk = 1'b0;
    end
    sda_m = ~mack;
    if (!mack) begin
      push_slot("nak_release", 1'b1);
      slot_chk = 1'b1;
    end
    clk_pulse();
    slot_chk = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    smp_bits = v;
    smp_vld = 1'b1;
    @(negedge clk);
    smp_vld = 1'b0;
  endtask

  task automatic write_conf(input logic [7:0] v);
    i2c_start();
    wbyte(8'h9C, 1'b1);
    wbyte(8'h09, 1'b1);
    conf_exp.push_back(v);
    wbyte(v, 1'b1);
    i2c_stop();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp2;
    int cyc;
    repeat (3) @(negedge clk);
    chk("reset_sda_oe", 32'(sda_oe), 32'd0);
    chk("reset_conf_bits", 32'(conf_bits), 32'd0);
    chk("reset_conf_valid", 32'(conf_vld), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Config write: three ACKs and exactly one update pulse.
    write_conf(8'h04);

    // Sample read with a strobe landing mid-byte, then re-read of the new sample.
    strobe(8'hA5);
    i2c_start();
    wbyte(8'h9C, 1'b1);
    wbyte(8'h00, 1'b1);
    i2c_start();
    wbyte(8'h9D, 1'b1);
    fork
      rbyte(8'hA5, 1'b0);
      begin
        #(12*Q);
        strobe(8'h3C);
      end
    join
    quiet = 1'b1;
    i2c_stop();
    quiet = 1'b0;
    i2c_start();
    wbyte(8'h9C, 1'b1);
    wbyte(8'h00, 1'b1);
    i2c_start();
    wbyte(8'h9D, 1'b1);
    rbyte(8'h3C, 1'b0);
    i2c_stop();

    // Wrong address: never driven until STOP, then a good transaction.
    i2c_start();
    quiet = 1'b1;
    wbyte(8'h9A, 1'b0);
    wbyte(8'h55, 1'b0);
    i2c_stop();
    quiet = 1'b0;
    write_conf(8'h5A);

    // Unmapped register write is ACKed without touching config.
    i2c_start();
    wbyte(8'h9C, 1'b1);
    wbyte(8'h05, 1'b1);
    wbyte(8'h77, 1'b1);
    i2c_stop();

    // Two-byte read of the config register with master ACK.
    write_conf(8'h04);
`ifdef I2C_TARGET_AUTOINC_EN
    exp2 = 8'h00;
`else
    exp2 = 8'h04;
`endif
    i2c_start();
    wbyte(8'h9C, 1'b1);
    wbyte(8'h03, 1'b1);
    i2c_start();
    wbyte(8'h9D, 1'b1);
    rbyte(8'h04, 1'b1);
    rbyte(exp2, 1'b0);
    i2c_stop();

    // Reset while the target is pulling SDA low during a read.
    i2c_start();
    wbyte(8'h9C, 1'b1);
    wbyte(8'h03, 1'b1);
    i2c_start();
    wbyte(8'h9D, 1'b1);
    for (int i = 0; i < 2; i++) begin
      sda_m = 1'b1;
      push_slot("pre_reset_bit", 1'b0);
      slot_chk = 1'b1;
      clk_pulse();
      slot_chk = 1'b0;
    end
    cyc = 0;
    while (!sda_oe && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    chk("read_driving_low", 32'(sda_oe), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_sda_released", 32'(sda_oe), 32'd0);
    chk("rst_conf_cleared", 32'(conf_bits), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q;
    quiet = 1'b1;
    wbyte(8'h9C, 1'b0);
    quiet = 1'b0;
    i2c_start();
    wbyte(8'h9C, 1'b1);
    i2c_stop();

    repeat (20) @(negedge clk);
    chk("conf_queue_drained", 32'(conf_exp.size()), 32'd0);
    chk("slot_queue_drained", 32'(v_q.size()), 32'd0);
    chk("quiet_oe_cycles", 32'(quiet_viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_sensor_target.md
I2C_SENSOR_TARGET -- requirements
Module: i2c_sensor_target

Interface
REQ-001 SHALL have parameter DATA_DEPTH, 8, width of a data byte.
REQ-002 SHALL have parameter DEVICE_ADDR, 78, 7-bit target address matched against the first byte after START.
REQ-003 SHALL have parameter CONFIG_REGISTER_WRITE, 9, register index whose writes update the config register.
REQ-004 SHALL have parameter CONFIG_REGISTER_READ, 3, register index whose reads return the config register.
REQ-005 SHALL have parameter SENSOR_DATA, 0, register index whose reads return the latched sample.
REQ-006 SHALL have port i_clk  input  1  system clock, at least 16x SCL frequency; the only clock.
REQ-007 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_scl  input  1  I2C clock line, asynchronous to i_clk.
REQ-009 SHALL have port i_sda  input  1  I2C data line, asynchronous to i_clk.
REQ-010 SHALL have port o_sda_oe  output  1  1 = pull SDA low; 0 = release.
REQ-011 SHALL have port i_sample_bits  input  DATA_DEPTH  sensor sample.
REQ-012 SHALL have port i_sample_valid  input  1  1-cycle strobe capturing i_sample_bits.
REQ-013 SHALL have port o_conf_bits  output  DATA_DEPTH  current config register.
REQ-014 SHALL have port o_conf_valid  output  1  1-cycle pulse when o_conf_bits updates.

Function
REQ-015 SHALL pass i_scl/i_sda through 2-flop synchronizers; all edge detection on synchronized values (≤3 cycle input latency).
REQ-016 SHALL detect START as SDA fall while SCL high, STOP as SDA rise while SCL high; sample data on SCL rise; change o_sda_oe 1 cycle after detected SCL fall.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-018 SHALL go IDLE->ADDR on START; shift 8 bits MSB first in ADDR, 3-bit counter.
REQ-019 SHALL on address match: ADDR_ACK drives ACK for one SCL pulse, then REG if R/W=0, RDATA if R/W=1; on mismatch: no ACK, IGNORE.
REQ-020 SHALL in REG shift pointer byte, ACK in REG_ACK, then WDATA.
REQ-021 SHALL in WDATA shift byte, ACK in WDATA_ACK; if pointer = CONFIG_REGISTER_WRITE update o_conf_bits and pulse o_conf_valid at ACK start; other indices ACKed, data discarded; return to WDATA.
REQ-022 SHALL in RDATA load byte at state entry (SENSOR_DATA -> latched sample, CONFIG_REGISTER_READ -> o_conf_bits, other -> 0), drive inverted bit as o_sda_oe MSB first, release SDA in RDATA_ACK.
REQ-023 SHALL on master ACK in RDATA_ACK return to RDATA; on master NAK go IGNORE.
REQ-024 SHALL latch i_sample_bits on i_sample_valid; a strobe during RDATA does not change the byte being shifted.
REQ-025 SHALL on STOP in any state go IDLE, release SDA; on START in any non-IDLE state (repeated start) go ADDR, pointer retained.
REQ-026 SHALL in IGNORE never drive SDA; leave only on START or STOP.

Reset
REQ-027 SHALL on i_rst asynchronously set state IDLE, o_sda_oe 0, o_conf_bits 0, o_conf_valid 0, sample latch 0, pointer 0, synchronizers 1.
REQ-028 SHALL on reset mid-transfer release SDA immediately; next transaction requires a fresh START.

Configuration
REQ-029 SHALL with macro I2C_TARGET_AUTOINC_EN defined increment pointer after each data byte ACK (write or read), 8-bit wrap 255->0.
REQ-030 SHALL without I2C_TARGET_AUTOINC_EN keep pointer fixed for the whole transaction.

Verification
REQ-031 SHALL cover: START, 0x9C, 0x09, 0x04, STOP -> three ACKs, o_conf_bits=0x04, one o_conf_valid pulse.
REQ-032 SHALL cover: sample strobe 0xA5, START, 0x9C, 0x00, rSTART, 0x9D, master NAK -> byte read 0xA5, SDA released after NAK.
REQ-033 SHALL cover: START, 0x9A (wrong address) -> no ACK, o_sda_oe 0 until STOP, next valid transaction ACKed.
REQ-034 SHALL cover: after config 0x04, pointer 0x03 then 2-byte read with master ACK -> without macro 0x04,0x04; with macro 0x04,0x00.
REQ-035 SHALL cover: i_rst asserted mid-RDATA while driving 0 -> o_sda_oe 0 same cycle, o_conf_bits 0x00.
